// File: rtl/execute_mc_if.sv
// Request/response bundle for execute_mc: operation request handshake
// in one direction, registered result handshake in the other.
interface execute_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       flag;
    logic             err;

    // Requester side: issues operations and consumes results.
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag, err
    );

    // Execute unit side.
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag, err
    );
endinterface

// File: rtl/execute_mc.sv
// Multi-cycle execute unit: single-cycle ALU ops, shift-add multiply and
// restoring divide, with a registered result held until consumed.
module execute_mc #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    execute_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic [CNTW-1:0]  r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_acc;   // MUL partial product / DIV partial remainder
    logic [WIDTH-1:0] r_x;     // MUL multiplicand / DIV dividend->quotient
    logic [WIDTH-1:0] r_y;     // MUL multiplier / DIV divisor
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_flag;
    logic             r_err;

    logic             w_in_ready, w_fire, w_single, w_err1, w_ofl1, w_last;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff, w_btr, w_res1, w_resmc, w_mul_acc;
    logic [2*WIDTH-1:0] w_rol2;
    logic [WIDTH:0]   w_div_t, w_div_sub;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
    logic             w_unused;

    function automatic logic [2:0] mk_flag(input logic [WIDTH-1:0] r, input logic o);
        return {r[WIDTH-1], o, (r == '0)};
    endfunction

    assign w_in_ready = (r_state == S_IDLE) || (r_state == S_DONE && bus.out_ready);
    assign w_fire     = bus.in_valid && w_in_ready;

    assign w_shamt = bus.b[SHW-1:0];
    assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff  = bus.a - bus.b;
    assign w_rol2  = {bus.a, bus.a} << w_shamt;

    // Divide by zero short-circuits; everything except MUL and real divides is one cycle.
    assign w_err1   = (bus.op[3:1] == 3'b111) && (bus.b == '0);
    assign w_single = (bus.op != 4'd13) && !((bus.op[3:1] == 3'b111) && (bus.b != '0));

    // Bit reversal of operand a.
    always_comb begin
        w_btr = '0;
        for (int i = 0; i < WIDTH; i++) w_btr[i] = bus.a[WIDTH-1-i];
    end

    // Single-cycle result and signed overflow for ADD/SUB.
    always_comb begin
        w_res1 = '0;
        w_ofl1 = 1'b0;
        case (bus.op)
            4'd0: begin
                w_res1 = w_sum[WIDTH-1:0];
                w_ofl1 = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd1: begin
                w_res1 = w_diff;
                w_ofl1 = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2:  w_res1 = bus.a & bus.b;
            4'd3:  w_res1 = bus.a | bus.b;
            4'd4:  w_res1 = bus.a ^ bus.b;
            4'd5:  w_res1 = bus.a << w_shamt;
            4'd6:  w_res1 = bus.a >> w_shamt;
            4'd7:  w_res1 = w_rol2[2*WIDTH-1:WIDTH];
            4'd8:  w_res1 = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'd9:  w_res1 = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            4'd10: w_res1 = {{(WIDTH-1){1'b0}}, ($signed(bus.a) <= $signed(bus.b))};
            4'd11: w_res1 = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            4'd12: w_res1 = w_btr;
            4'd14: w_res1 = '1;
            4'd15: w_res1 = bus.a;
            default: w_res1 = '0;
        endcase
    end

    // One multiply step and one restoring-divide step per BUSY cycle.
    assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);
    assign w_div_t   = {r_acc, r_x[WIDTH-1]};
    assign w_div_ge  = (w_div_t >= {1'b0, r_y});
    assign w_div_sub = w_div_t - {1'b0, r_y};
    assign w_rem_nxt = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_t[WIDTH-1:0];
    assign w_quo_nxt = {r_x[WIDTH-2:0], w_div_ge};
    assign w_resmc   = (r_op == 4'd13) ? w_mul_acc : ((r_op == 4'd14) ? w_quo_nxt : w_rem_nxt);
    assign w_last    = (r_cnt == CNTW'(WIDTH-1));
    // The subtract's top bit is always zero when selected (remainder < divisor).
    assign w_unused  = w_div_sub[WIDTH];

    // Control FSM with registered result/flag/err and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag      <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == 4'd13) begin
                        r_acc <= w_mul_acc;
                        r_x   <= r_x << 1;
                        r_y   <= r_y >> 1;
                    end else begin
                        r_acc <= w_rem_nxt;
                        r_x   <= w_quo_nxt;
                    end
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_resmc;
                        r_flag      <= mk_flag(w_resmc, 1'b0);
                        r_err       <= 1'b0;
                    end
                end
                default: begin
                    if (w_fire) begin
                        r_op <= bus.op;
                        if (w_single) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res1;
                            r_flag      <= mk_flag(w_res1, w_ofl1);
                            r_err       <= w_err1;
                        end else begin
                            r_state     <= S_BUSY;
                            r_out_valid <= 1'b0;
                            r_cnt       <= '0;
                            r_acc       <= '0;
                            r_x         <= bus.a;
                            r_y         <= bus.b;
                        end
                    end else if (r_state == S_DONE && bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flag      = r_flag;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: vector tables for WIDTH=16 and WIDTH=8
// plus hand sequences for backpressure, busy blocking and mid-op reset.
module tb_execute_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    execute_mc_if #(.WIDTH(16)) bus16();
    execute_mc_if #(.WIDTH(8))  bus8();

    execute_mc #(.WIDTH(16), .CNTW(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    execute_mc #(.WIDTH(8),  .CNTW(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flg;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tv16[$];
    vec_t tv8[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic addv(inout vec_t q[$], input string nm, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                        input logic [2:0] flg, input logic err, input int lat);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b;
        v.res = res; v.flg = flg; v.err = err; v.lat = lat;
        q.push_back(v);
    endtask

    // Fire one op on the 16-bit unit, wait (bounded) for the result, then consume it.
    task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic [2:0] flg, output logic err,
                         output int lat);
        bus16.op = op; bus16.a = a; bus16.b = b; bus16.in_valid = 1'b1; bus16.out_ready = 1'b0;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus16.result; flg = bus16.flag; err = bus16.err;
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [2:0] flg, output logic err,
                        output int lat);
        bus8.op = op; bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus8.result; flg = bus8.flag; err = bus8.err;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] r16;
        logic [7:0]  r8;
        logic [2:0]  f;
        logic        e;
        int          lat;
        logic        busy_rdy;

        //            name         op     a         b         result    flag    err lat
        addv(tv16, "ADD_ofl",  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 3'b110, 0, 1);
        addv(tv16, "SUB_zero", 4'd1,  16'h0005, 16'h0005, 16'h0000, 3'b001, 0, 1);
        addv(tv16, "SUB_ofl",  4'd1,  16'h8000, 16'h0001, 16'h7FFF, 3'b010, 0, 1);
        addv(tv16, "AND",      4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 3'b000, 0, 1);
        addv(tv16, "OR",       4'd3,  16'hF0F0, 16'h0F00, 16'hFFF0, 3'b100, 0, 1);
        addv(tv16, "XOR",      4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 3'b001, 0, 1);
        addv(tv16, "SLL",      4'd5,  16'h0001, 16'h0013, 16'h0008, 3'b000, 0, 1);
        addv(tv16, "SRL",      4'd6,  16'h8000, 16'h000F, 16'h0001, 3'b000, 0, 1);
        addv(tv16, "ROL",      4'd7,  16'h8001, 16'h0004, 16'h0018, 3'b000, 0, 1);
        addv(tv16, "SLT",      4'd8,  16'hFFFF, 16'h0001, 16'h0001, 3'b000, 0, 1);
        addv(tv16, "SEQ",      4'd9,  16'h1234, 16'h1234, 16'h0001, 3'b000, 0, 1);
        addv(tv16, "SLE_eq",   4'd10, 16'h0005, 16'h0005, 16'h0001, 3'b000, 0, 1);
        addv(tv16, "SLE_gt",   4'd10, 16'h0006, 16'h0005, 16'h0000, 3'b001, 0, 1);
        addv(tv16, "SCO_c1",   4'd11, 16'hFFFF, 16'h0001, 16'h0001, 3'b000, 0, 1);
        addv(tv16, "SCO_c0",   4'd11, 16'h0001, 16'h0001, 16'h0000, 3'b001, 0, 1);
        addv(tv16, "BTR",      4'd12, 16'h0001, 16'h0000, 16'h8000, 3'b100, 0, 1);
        addv(tv16, "MUL",      4'd13, 16'h0123, 16'h0010, 16'h1230, 3'b000, 0, 17);
        addv(tv16, "MUL_wrap", 4'd13, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b000, 0, 17);
        addv(tv16, "DIVU",     4'd14, 16'd100,  16'd7,    16'd14,   3'b000, 0, 17);
        addv(tv16, "REMU",     4'd15, 16'd100,  16'd7,    16'd2,    3'b000, 0, 17);
        addv(tv16, "DIVU_big", 4'd14, 16'hFFFF, 16'h0001, 16'hFFFF, 3'b100, 0, 17);
        addv(tv16, "DIVU_b0",  4'd14, 16'h1234, 16'h0000, 16'hFFFF, 3'b100, 1, 1);
        addv(tv16, "REMU_b0",  4'd15, 16'h1234, 16'h0000, 16'h1234, 3'b000, 1, 1);

        addv(tv8,  "W8_SLT",   4'd8,  16'h0080, 16'h0001, 16'h0001, 3'b000, 0, 1);
        addv(tv8,  "W8_BTR",   4'd12, 16'h0001, 16'h0000, 16'h0080, 3'b100, 0, 1);
        addv(tv8,  "W8_MUL",   4'd13, 16'h0010, 16'h0010, 16'h0000, 3'b001, 0, 9);
        addv(tv8,  "W8_DIVU",  4'd14, 16'd200,  16'd9,    16'd22,   3'b000, 0, 9);
        addv(tv8,  "W8_REMU",  4'd15, 16'd200,  16'd9,    16'd2,    3'b000, 0, 9);

        bus16.in_valid = 0; bus16.op = 0; bus16.a = 0; bus16.b = 0; bus16.out_ready = 0;
        bus8.in_valid  = 0; bus8.op  = 0; bus8.a  = 0; bus8.b  = 0; bus8.out_ready  = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_result",    32'(bus16.result),    32'd0);
        chk("rst_flag",      32'(bus16.flag),      32'd0);
        chk("rst_err",       32'(bus16.err),       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready",  32'(bus16.in_ready),  32'd1);

        // Table-driven single ops, 16-bit.
        foreach (tv16[i]) begin
            run16(tv16[i].op, tv16[i].a, tv16[i].b, r16, f, e, lat);
            chk({tv16[i].name, "_res"}, 32'(r16), 32'(tv16[i].res));
            chk({tv16[i].name, "_flag"}, 32'(f), 32'(tv16[i].flg));
            chk({tv16[i].name, "_err"}, 32'(e), 32'(tv16[i].err));
            chk({tv16[i].name, "_lat"}, 32'(lat), 32'(tv16[i].lat));
        end

        // Table-driven single ops, 8-bit build.
        foreach (tv8[i]) begin
            run8(tv8[i].op, tv8[i].a[7:0], tv8[i].b[7:0], r8, f, e, lat);
            chk({tv8[i].name, "_res"}, 32'(r8), 32'(tv8[i].res));
            chk({tv8[i].name, "_flag"}, 32'(f), 32'(tv8[i].flg));
            chk({tv8[i].name, "_err"}, 32'(e), 32'(tv8[i].err));
            chk({tv8[i].name, "_lat"}, 32'(lat), 32'(tv8[i].lat));
        end

        // Backpressure: hold DONE for 5 cycles, then back-to-back fire.
        bus16.op = 4'd0; bus16.a = 16'd1; bus16.b = 16'd2; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", 32'(bus16.out_valid), 32'd1);
            chk("stall_result",    32'(bus16.result),    32'd3);
            chk("stall_flag",      32'(bus16.flag),      32'd0);
            chk("stall_in_ready",  32'(bus16.in_ready),  32'd0);
            @(posedge clk); #1;
        end
        bus16.out_ready = 1'b1;
        bus16.op = 4'd1; bus16.a = 16'd9; bus16.b = 16'd4; bus16.in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(bus16.in_ready), 32'd1);
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        chk("b2b_out_valid", 32'(bus16.out_valid), 32'd1);
        chk("b2b_result",    32'(bus16.result),    32'd5);
        @(posedge clk); #1;
        chk("drain_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("drain_in_ready",  32'(bus16.in_ready),  32'd1);
        bus16.out_ready = 1'b0;

        // MUL with in_valid held high throughout BUSY: requests must be ignored.
        bus16.op = 4'd13; bus16.a = 16'h0123; bus16.b = 16'h0010; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.op = 4'd0; bus16.a = 16'd1; bus16.b = 16'd1;
        busy_rdy = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 64) begin
            if (bus16.in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_in_ready_seen", 32'(busy_rdy),       32'd0);
        chk("busy_mul_lat",       32'(lat),            32'd17);
        chk("busy_mul_res",       32'(bus16.result),   32'h1230);
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;

        // Reset in the 8th BUSY cycle of a MUL.
        bus16.op = 4'd13; bus16.a = 16'h0123; bus16.b = 16'h0010; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("midrst_busy_in_ready", 32'(bus16.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("midrst_result",    32'(bus16.result),    32'd0);
        chk("midrst_in_ready",  32'(bus16.in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_out_valid", 32'(bus16.out_valid), 32'd0);
        run16(4'd1, 16'd5, 16'd5, r16, f, e, lat);
        chk("postrst_sub_res",  32'(r16), 32'd0);
        chk("postrst_sub_flag", 32'(f),   32'b001);
        chk("postrst_sub_lat",  32'(lat), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
